// File: rtl/xnor_cmp_arb.sv
// ============================================================================
// Module      : xnor_cmp_arb
// Description : Two-requester round-robin arbiter that runs an equality check
//               bit-serially, LSB first, through one external 1-bit XNOR cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xnor_cmp_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             xa,
  output logic             xb,
  input  logic             xs,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             owner
);

  localparam int             IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] c_last_idx = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [IW-1:0]    r_idx;
  logic             r_acc;
  logic             r_eq;
  logic             r_owner;
  logic             r_pri;      // requester that wins a simultaneous request
  logic             w_any_req;
  logic             w_winner;
  logic             w_last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_any_req  = req0 | req1;
    w_winner   = (req0 & req1) ? r_pri : req1;
    w_last_bit = (r_idx == c_last_idx);
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    xa         = 1'b0;
    xb         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    eq         = r_eq;
    owner      = r_owner;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        xa   = r_sa[0];
        xb   = r_sb[0];
        // Grant is visible only in the first shift cycle, when index is still 0
        gnt0 = (r_idx == '0) & ~r_owner;
        gnt1 = (r_idx == '0) &  r_owner;
        if (w_last_bit) begin
          w_next = DONE;
        end
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_idx   <= '0;
      r_acc   <= 1'b1;
      r_eq    <= 1'b0;
      r_owner <= 1'b0;
      r_pri   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_sa    <= w_winner ? a1 : a0;
            r_sb    <= w_winner ? b1 : b0;
            r_idx   <= '0;
            r_acc   <= 1'b1;
            r_owner <= w_winner;
            r_pri   <= ~w_winner;
          end
        end
        SHIFT: begin
          r_acc <= r_acc & xs;
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          if (w_last_bit) begin
            r_idx <= '0;
            r_eq  <= r_acc & xs;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire
